// File: rtl/tt_instrn_trace_buf.sv
// Retired-instruction trace buffer: circular capture of {pc, instrn} while armed,
// freeze a programmable number of retires after a PC-match trigger, then stream oldest-first.
module tt_instrn_trace_buf #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_arm,
  input  logic             i_retire_vld,
  input  logic [PC_W-1:0]  i_retire_pc,
  input  logic [31:0]      i_retire_instrn,
  input  logic             i_trig_en,
  input  logic [PC_W-1:0]  i_trig_pc,
  input  logic [CNT_W-1:0] i_post_trig_cnt,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_count,
  output logic             o_rd_vld,
  input  logic             i_rd_rdy,
  output logic [PC_W-1:0]  o_rd_pc,
  output logic [31:0]      o_rd_instrn,
  output logic             o_rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_POST = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_FROZEN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, remaining_q, remaining_d, post_cnt_q, post_cnt_d;
  logic [PC_W+31:0] mem [DEPTH];
  logic             capture, trig, xfer, freeze;
  logic [PC_W+31:0] rd_word;

  // An arm in the same cycle drops both the retire and any readout transfer.
  assign capture  = i_retire_vld & ~i_arm & ((state_q == S_ARMED) | (state_q == S_POST));
  assign trig     = capture & (state_q == S_ARMED) & i_trig_en & (i_retire_pc == i_trig_pc);
  assign o_rd_vld = (state_q == S_FROZEN) & (remaining_q != '0);
  assign xfer     = o_rd_vld & i_rd_rdy & ~i_arm;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    post_cnt_d  = post_cnt_q;
    freeze      = 1'b0;
    if (i_arm) begin
      state_d     = S_ARMED;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      remaining_d = '0;
      post_cnt_d  = '0;
    end else begin
      if (capture) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = (count_q == FULL) ? count_q : count_q + CNT_W'(1);
      end
      case (state_q)
        S_ARMED: begin
          if (trig) begin
            post_cnt_d = (i_post_trig_cnt > MAX_POST) ? MAX_POST : i_post_trig_cnt;
            if (post_cnt_d == '0) freeze = 1'b1;
            else                  state_d = S_POST;
          end
        end
        S_POST: begin
          if (capture) begin
            post_cnt_d = post_cnt_q - CNT_W'(1);
            if (post_cnt_q == CNT_W'(1)) freeze = 1'b1;
          end
        end
        S_FROZEN: begin
          if (xfer) begin
            rd_ptr_d    = rd_ptr_q + AW'(1);
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) state_d = S_IDLE;
          end
        end
        default: ;
      endcase
      // Oldest entry sits at wr_ptr once the buffer has wrapped, else at slot 0.
      if (freeze) begin
        state_d     = S_FROZEN;
        rd_ptr_d    = (count_d == FULL) ? wr_ptr_d : '0;
        remaining_d = count_d;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      post_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      post_cnt_q  <= post_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (capture) mem[wr_ptr_q] <= {i_retire_pc, i_retire_instrn};
  end

  assign rd_word     = mem[rd_ptr_q];
  assign o_state     = state_q;
  assign o_count     = count_q;
  assign o_rd_pc     = o_rd_vld ? rd_word[PC_W+31:32] : '0;
  assign o_rd_instrn = o_rd_vld ? rd_word[31:0] : '0;
  assign o_rd_last   = o_rd_vld & (remaining_q == CNT_W'(1));

endmodule
